// File: rtl/adc_pkg.sv
// Purpose: constants shared by the SAR ADC sequencer and the SPI register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Holds the sequencer state encoding, the SPI register map and the ctrl_reg bit layout.
package adc_pkg;

    // Sequencer state encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAMPLE  = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // SPI register map shared with adc_spi_slave
    localparam logic [7:0] ADDR_CTRL_REG   = 8'h00;
    localparam logic [7:0] ADDR_STATUS_REG = 8'h01;
    localparam logic [7:0] ADDR_DATA_REG   = 8'h02;
    localparam logic [7:0] ADDR_OFFSET_REG = 8'h03;

    // ctrl_reg bit positions
    localparam int unsigned CTRL_START_BIT     = 0;
    localparam int unsigned CTRL_CONT_MODE_BIT = 1;
    localparam int unsigned CTRL_ABORT_BIT     = 2;

endpackage

// File: rtl/sar_offset_sat.sv
// Purpose: saturating subtract, diff_dat = max(minuend_dat - subtrahend_dat, 0).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   minuend_dat    : raw SAR code
//   subtrahend_dat : offset to remove
//   diff_dat       : corrected code, clamped at 0 instead of wrapping
module sar_offset_sat #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] minuend_dat,
    input  logic [WIDTH-1:0] subtrahend_dat,
    output logic [WIDTH-1:0] diff_dat
);

    assign diff_dat = (minuend_dat >= subtrahend_dat) ? (minuend_dat - subtrahend_dat) : '0;

endmodule

// File: rtl/sar_adc_sequencer.sv
// Purpose: SAR ADC conversion controller (sample, binary search, offset-corrected result).
// Latency: done at cycle 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) after start.
// Backpressure: none; start while busy is dropped and flagged in sticky overrun.
//   Inputs : clk, reset_ (async, active-high), start, cont_mode, abort, offset, clr_overrun, comp_in
//   Outputs: sample_en, dac_code, busy, done, result, result_valid, overrun
module sar_adc_sequencer
    import adc_pkg::*;
#(
    parameter int WIDTH         = 12,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] offset,
    input  logic             clr_overrun,
    input  logic             comp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    localparam int IDX_W   = $clog2(WIDTH);
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_BIT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sar;
    logic [WIDTH-1:0] trial_bit;
    logic [WIDTH-1:0] sar_upd;
    logic [WIDTH-1:0] sat_dat;

    // Bit under test this COMPARE; sar has it clear, so OR-ing keeps it only when comp_in=1.
    assign trial_bit = LSB_BIT << idx;
    assign sar_upd   = comp_in ? (sar | trial_bit) : sar;

    // Status decoded straight from the state register so they track it cycle for cycle.
    assign busy      = (state != S_IDLE);
    assign sample_en = (state == S_SAMPLE);
    assign done      = (state == S_DONE);

    // Offset is removed from the final code (including the LSB decided this cycle),
    // so result is already updated while done is high.
    sar_offset_sat #(
        .WIDTH (WIDTH)
    ) u_offset_sat (
        .minuend_dat    (sar_upd),
        .subtrahend_dat (offset),
        .diff_dat       (sat_dat)
    );

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            sar          <= '0;
            dac_code     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // A new overrun event beats a simultaneous clear.
            if (start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            if (abort && (state != S_IDLE)) begin
                state    <= S_IDLE;
                cnt      <= '0;
                sar      <= '0;
                dac_code <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt      <= '0;
                        sar      <= '0;
                        dac_code <= '0;
                        if (!abort && (start || cont_mode)) begin
                            state <= S_SAMPLE;
                        end
                    end
                    S_SAMPLE: begin
                        if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                            cnt      <= '0;
                            idx      <= IDX_W'(WIDTH - 1);
                            dac_code <= sar | MSB_BIT;
                            state    <= S_SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= S_COMPARE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_COMPARE: begin
                        sar <= sar_upd;
                        if (idx == '0) begin
                            result       <= sat_dat;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            idx      <= idx - 1'b1;
                            dac_code <= sar_upd | (trial_bit >> 1);
                            state    <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        // sar restarts from zero for the next search; dac_code keeps the
                        // last trial through a continuous-mode SAMPLE phase.
                        sar <= '0;
                        cnt <= '0;
                        if (cont_mode) begin
                            state <= S_SAMPLE;
                        end else begin
                            dac_code <= '0;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        dac_code <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
module tb_sar_adc_sequencer;

    localparam int WIDTH = 12;
    localparam int SAMPLE_CYCLES = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int LAT = 1 + SAMPLE_CYCLES + WIDTH * (SETTLE_CYCLES + 1);

    logic             clk;
    logic             reset_;
    logic             start;
    logic             cont_mode;
    logic             abort;
    logic [WIDTH-1:0] offset;
    logic             clr_overrun;
    logic             comp_in;
    logic             sample_en;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overrun;

    logic [WIDTH-1:0] vin;

    int checks = 0;
    int errors = 0;

    // Ideal comparator: analog input modelled as an integer code.
    assign comp_in = (vin >= dac_code);

    sar_adc_sequencer #(
        .WIDTH         (WIDTH),
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .start        (start),
        .cont_mode    (cont_mode),
        .abort        (abort),
        .offset       (offset),
        .clr_overrun  (clr_overrun),
        .comp_in      (comp_in),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An ideal SAR converges on the input code; the offset is then removed with clamping at 0.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] o);
        int diff;
        diff = int'(v) - int'(o);
        return (diff < 0) ? '0 : WIDTH'(diff);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {4'h0, sample_en, dac_code, busy, done, result, result_valid, overrun};
    endfunction

    // One single-shot conversion; optionally fires start+clr_overrun together at cycle ovr_at.
    task automatic convert(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] o,
                           input string tag, input int ovr_at);
        int n;
        int se_cnt;
        int busy_lo;
        vin    = v;
        offset = o;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        n       = 1;
        se_cnt  = 0;
        busy_lo = 0;
        while (!done && n < 200) begin
            if (sample_en) se_cnt++;
            if (!busy) busy_lo++;
            start       = (ovr_at != 0) && (n == ovr_at);
            clr_overrun = (ovr_at != 0) && (n == ovr_at);
            tick();
            n++;
        end
        start       = 1'b0;
        clr_overrun = 1'b0;
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_result"}, result, model(v, o));
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_sample_cycles"}, se_cnt, SAMPLE_CYCLES);
        chk({tag, "_busy_held"}, busy_lo, 0);
        chk({tag, "_overrun"}, overrun, (ovr_at != 0));
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_dac"}, dac_code, 0);
    endtask

    initial begin
        int n;
        int first;
        int second;
        int busy_lo;
        int done_cnt;
        logic [WIDTH-1:0] rv;
        logic [WIDTH-1:0] ro;

        reset_      = 1'b1;
        start       = 1'b0;
        cont_mode   = 1'b0;
        abort       = 1'b0;
        offset      = '0;
        clr_overrun = 1'b0;
        vin         = '0;
        tick();
        chk("reset_outputs", all_outs(), 0);
        tick();
        reset_ = 1'b0;
        tick();
        chk("post_reset_outputs", all_outs(), 0);

        // Directed conversions, including offset saturation
        convert(12'hA5A, 12'h000, "a5a", 0);
        convert(12'h005, 12'h010, "sat", 0);
        convert(12'h800, 12'h010, "sub", 0);

        // start during a conversion, coinciding with clr_overrun: set wins
        convert(12'h3C3, 12'h003, "ovr", 10);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_overrun", overrun, 0);

        // Continuous mode: back-to-back conversions with busy never dropping
        cont_mode = 1'b1;
        vin       = 12'h123;
        offset    = '0;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        n       = 1;
        first   = 0;
        second  = 0;
        busy_lo = 0;
        while (n < 200 && second == 0) begin
            if (!busy) busy_lo++;
            if (first != 0 && n == first + 1) cont_mode = 1'b0;
            if (done) begin
                if (first == 0) begin
                    first = n;
                    chk("cont_result1", result, 12'h123);
                    vin = 12'hFFF;
                end else begin
                    second = n;
                    chk("cont_result2", result, 12'hFFF);
                end
            end
            if (second == 0) begin
                tick();
                n++;
            end
        end
        chk("cont_first_at", first, LAT);
        chk("cont_gap", second - first, LAT);
        chk("cont_busy_held", busy_lo, 0);
        tick();
        chk("cont_stop_busy", busy, 0);

        // Abort mid-conversion leaves the previous result untouched
        convert(12'h0AA, 12'h000, "pre_abort", 0);
        vin   = 12'h555;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        while (n < 20) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dac", dac_code, 0);
        chk("abort_sample_en", sample_en, 0);
        chk("abort_result", result, 12'h0AA);
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_valid_kept", result_valid, 1);

        // Randomized conversions against the model
        for (int i = 0; i < 8; i++) begin
            rv = WIDTH'($urandom_range(0, 4095));
            ro = (i % 2 == 1) ? WIDTH'($urandom_range(0, 4095)) : WIDTH'($urandom_range(0, 255));
            convert(rv, ro, $sformatf("rand%0d", i), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Asynchronous reset in the middle of SETTLE
        vin    = 12'h777;
        offset = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        while (n < 6) begin
            tick();
            n++;
        end
        chk("pre_reset_busy", busy, 1);
        reset_ = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        tick();
        reset_ = 1'b0;
        tick();
        convert(12'h000, 12'h000, "zero", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
